// File: rtl/minisrc_pkg.sv
// Shared definitions for the Mini SRC control sequencer.
// Provides the 5-bit opcode map, the T-state encoding, and an opcode-class
// decoder so the output decode can select an execute sequence per class.
package minisrc_pkg;

    localparam int unsigned OP_W   = 5;
    localparam int unsigned STEP_W = 4;

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b01000;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01001;
    localparam logic [OP_W-1:0] OP_AND  = 5'b01010;
    localparam logic [OP_W-1:0] OP_OR   = 5'b01011;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
    localparam logic [OP_W-1:0] OP_JR   = 5'b10100;
    localparam logic [OP_W-1:0] OP_JAL  = 5'b10101;
    localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
    localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
    localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
    localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    // T-state index; HALT sits outside the T0..T7 range
    typedef enum logic [STEP_W-1:0] {
        T0   = 4'd0,
        T1   = 4'd1,
        T2   = 4'd2,
        T3   = 4'd3,
        T4   = 4'd4,
        T5   = 4'd5,
        T6   = 4'd6,
        T7   = 4'd7,
        HALT = 4'd8
    } step_t;

    typedef enum logic [3:0] {
        CL_NOP, CL_ALU_R, CL_ALU_I, CL_MULDIV, CL_UNARY, CL_LD, CL_ST,
        CL_BR, CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_HALT
    } op_class_t;

    // Groups opcodes sharing an execute sequence; unknown codes fall to nop
    function automatic op_class_t op_class(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:            return CL_ALU_R;
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:         return CL_ALU_I;
            OP_MUL, OP_DIV:                           return CL_MULDIV;
            OP_NEG, OP_NOT:                           return CL_UNARY;
            OP_LD:                                    return CL_LD;
            OP_ST:                                    return CL_ST;
            OP_BR:                                    return CL_BR;
            OP_JR:                                    return CL_JR;
            OP_JAL:                                   return CL_JAL;
            OP_IN:                                    return CL_IN;
            OP_OUT:                                   return CL_OUT;
            OP_MFHI:                                  return CL_MFHI;
            OP_MFLO:                                  return CL_MFLO;
            OP_HALT:                                  return CL_HALT;
            default:                                  return CL_NOP;
        endcase
    endfunction

endpackage

// File: rtl/control_step_counter.sv
// T-state sequencer for the Mini SRC control unit.
// Ports: clk/rst_n (async active-low), stop (halt request), mem_wait (current
// step performs a RAM access), mem_done (RAM handshake), instr_end /
// instr_halt (decoded from the current step), step (current T-state), run.
module control_step_counter
    import minisrc_pkg::*;
#(
    parameter int unsigned MAX_STEP = 7
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  stop,
    input  logic  mem_wait,
    input  logic  mem_done,
    input  logic  instr_end,
    input  logic  instr_halt,
    output step_t step,
    output logic  run
);

    localparam step_t LAST_STEP = step_t'(STEP_W'(MAX_STEP));

    logic stop_pending;
    logic at_end;

    // Running past the last T-state always terminates the instruction
    assign at_end = instr_end || (step == LAST_STEP);

    // Step register: holds in memory steps until mem_done, HALT is sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step         <= T0;
            run          <= 1'b1;
            stop_pending <= 1'b0;
        end else begin
            stop_pending <= stop_pending | stop;
            if (step == HALT) begin
                run <= 1'b0;
            end else if (!mem_wait || mem_done) begin
                if (instr_halt || (at_end && stop_pending)) begin
                    step <= HALT;
                    run  <= 1'b0;
                end else if (at_end) begin
                    step <= T0;
                end else begin
                    step <= step_t'(step + STEP_W'(1));
                end
            end
        end
    end

endmodule

// File: rtl/minisrc_control_unit.sv
// Hardwired Moore control unit for the Mini SRC CPU.
// Ports: clock, clear (async active-low), ir (opcode in ir[31:27]), con_ff,
// mem_done, stop; outputs are every datapath control strobe, the ALU opcode
// and run. Strobes decode from the registered T-state and the IR opcode
// (plus con_ff for the conditional branch write).
module minisrc_control_unit
    import minisrc_pkg::*;
#(
    parameter int unsigned RESET_PC_SEL = 0,
    parameter int unsigned MAX_STEP     = 7
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        mem_done,
    input  logic        stop,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCout_en,
    output logic        IncPC,
    output logic        PC_en,
    output logic        IR_en,
    output logic        Yin,
    output logic        HIout,
    output logic        HIin,
    output logic        LOout,
    output logic        LOin,
    output logic        Cout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        Zin,
    output logic        MDRout,
    output logic        MDRin,
    output logic        MARin,
    output logic        memRead,
    output logic        memWrite,
    output logic        inPort_en,
    output logic        outPort_en,
    output logic        CONin,
    output logic [4:0]  opcode,
    output logic        run
);

    logic [OP_W-1:0] op;
    op_class_t       cls;
    step_t           step;
    logic            instr_end_c;
    logic            instr_halt_c;
    logic            mem_wait_c;
    logic            unused_bits;

    assign op          = ir[31:27];
    assign cls         = op_class(op);
    assign mem_wait_c  = memRead | memWrite;
    assign unused_bits = ^{ir[26:0], 32'(RESET_PC_SEL)};

    control_step_counter #(
        .MAX_STEP (MAX_STEP)
    ) u_step (
        .clk        (clock),
        .rst_n      (clear),
        .stop       (stop),
        .mem_wait   (mem_wait_c),
        .mem_done   (mem_done),
        .instr_end  (instr_end_c),
        .instr_halt (instr_halt_c),
        .step       (step),
        .run        (run)
    );

    // Control strobe decode per T-state and opcode class
    always_comb begin
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        BAout = 1'b0; PCout_en = 1'b0; IncPC = 1'b0; PC_en = 1'b0;
        IR_en = 1'b0; Yin = 1'b0; HIout = 1'b0; HIin = 1'b0; LOout = 1'b0;
        LOin = 1'b0; Cout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
        Zin = 1'b0; MDRout = 1'b0; MDRin = 1'b0; MARin = 1'b0;
        memRead = 1'b0; memWrite = 1'b0; inPort_en = 1'b0;
        outPort_en = 1'b0; CONin = 1'b0; opcode = '0;
        instr_end_c = 1'b0; instr_halt_c = 1'b0;

        case (step)
            T0: begin
                PCout_en = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                opcode = OP_ADD;
            end
            T1: begin
                Zlowout = 1'b1; PC_en = 1'b1; memRead = 1'b1; MDRin = 1'b1;
            end
            T2: begin
                MDRout = 1'b1; IR_en = 1'b1;
            end
            T3: begin
                case (cls)
                    CL_ALU_R:  begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CL_ALU_I: begin
                        Grb = 1'b1; Yin = 1'b1;
                        if (op == OP_LDI) BAout = 1'b1;
                        else              Rout  = 1'b1;
                    end
                    CL_MULDIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CL_UNARY: begin
                        Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op;
                    end
                    CL_LD, CL_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    CL_BR:    begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    CL_JR: begin
                        Gra = 1'b1; Rout = 1'b1; PC_en = 1'b1; instr_end_c = 1'b1;
                    end
                    // Link register is named by the rb field of jal
                    CL_JAL:   begin PCout_en = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                    CL_IN: begin
                        inPort_en = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_end_c = 1'b1;
                    end
                    CL_OUT: begin
                        Gra = 1'b1; Rout = 1'b1; outPort_en = 1'b1; instr_end_c = 1'b1;
                    end
                    CL_MFHI: begin
                        HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_end_c = 1'b1;
                    end
                    CL_MFLO: begin
                        LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_end_c = 1'b1;
                    end
                    CL_HALT:  instr_halt_c = 1'b1;
                    default:  instr_end_c  = 1'b1;
                endcase
            end
            T4: begin
                case (cls)
                    CL_ALU_R: begin
                        Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op;
                    end
                    CL_ALU_I: begin
                        Cout = 1'b1; Zin = 1'b1;
                        opcode = (op == OP_LDI) ? OP_ADD : op;
                    end
                    CL_MULDIV: begin
                        Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op;
                    end
                    CL_UNARY: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_end_c = 1'b1;
                    end
                    CL_LD, CL_ST: begin Cout = 1'b1; Zin = 1'b1; opcode = OP_ADD; end
                    CL_BR:    begin PCout_en = 1'b1; Yin = 1'b1; end
                    CL_JAL: begin
                        Gra = 1'b1; Rout = 1'b1; PC_en = 1'b1; instr_end_c = 1'b1;
                    end
                    default:  instr_end_c = 1'b1;
                endcase
            end
            T5: begin
                case (cls)
                    CL_ALU_R, CL_ALU_I: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_end_c = 1'b1;
                    end
                    CL_MULDIV:    begin Zlowout = 1'b1; LOin = 1'b1; end
                    CL_LD, CL_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
                    CL_BR:        begin Cout = 1'b1; Zin = 1'b1; opcode = OP_ADD; end
                    default:      instr_end_c = 1'b1;
                endcase
            end
            T6: begin
                case (cls)
                    CL_MULDIV: begin
                        Zhighout = 1'b1; HIin = 1'b1; instr_end_c = 1'b1;
                    end
                    CL_LD:   begin memRead = 1'b1; MDRin = 1'b1; end
                    CL_ST:   begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    CL_BR: begin
                        // Branch target is written only when the condition held
                        Zlowout = con_ff; PC_en = con_ff; instr_end_c = 1'b1;
                    end
                    default: instr_end_c = 1'b1;
                endcase
            end
            T7: begin
                instr_end_c = 1'b1;
                case (cls)
                    CL_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_ST:   memWrite = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule
